card_display_scan: RTL and testbench

Time-multiplexed driver for the 8-digit seven-segment display showing a hand of up to NUM_CARDS cards, each as a rank digit followed by a suit digit. It sits between game logic, which posts a new hand over a valid/ready handshake, and the board's shared cathode bus and per-digit anodes. It double-buffers the hand so updates take effect only at frame boundaries, with no tearing. It inserts a blanking guard at each digit switch to suppress ghosting.

---
 rtl/card_pkg.sv | 45 ++++
 rtl/bto7s_suit.sv | 23 ++
 rtl/scan_prescaler.sv | 79 +++++++
 rtl/card_display_scan.sv | 216 +++++++++++++++++++++
 tb/tb_card_display_scan.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/card_pkg.sv
// card_pkg: shared definitions for the card display datapath.
//   suit_e        - two-bit suit encoding (diamond, heart, club, spade)
//   card_t        - packed card {rank[3:0], suit[1:0]}; rank 0 means "no card"
//   scan_phase_e  - BLANK/DRIVE phase of one digit slot
//   SUIT_GLYPH    - segment patterns (gfedcba, active-high) per suit
//   RANK_GLYPH    - segment patterns per rank; 14/15 show a dash
package card_pkg;

  typedef enum logic [1:0] {
    SUIT_DIAMOND = 2'b00,
    SUIT_HEART   = 2'b01,
    SUIT_CLUB    = 2'b10,
    SUIT_SPADE   = 2'b11
  } suit_e;

  typedef struct packed {
    logic [3:0] rank;
    logic [1:0] suit;
  } card_t;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } scan_phase_e;

  localparam logic [3:0] RANK_EMPTY  = 4'd0;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;

  // Element 0 is the rightmost entry of each concatenation.
  localparam logic [3:0][6:0] SUIT_GLYPH = {7'h6D, 7'h39, 7'h74, 7'h5E};

  localparam logic [15:0][6:0] RANK_GLYPH = {
    GLYPH_DASH, GLYPH_DASH,                  // 15, 14: illegal ranks
    7'h75, 7'h67, 7'h1E, 7'h78,              // 13 K, 12 Q, 11 J, 10
    7'h6F, 7'h7F, 7'h07, 7'h7D,              // 9, 8, 7, 6
    7'h6D, 7'h66, 7'h4F, 7'h5B,              // 5, 4, 3, 2
    7'h77, GLYPH_BLANK                       // 1 A, 0 empty
  };

  function automatic logic [6:0] rank_glyph(input logic [3:0] rank);
    return RANK_GLYPH[rank];
  endfunction

endpackage

// File: rtl/bto7s_suit.sv
// bto7s_suit: suit code to seven-segment glyph decoder.
//   suit_in   [1:0]  suit encoding (card_pkg::suit_e)
//   glyph_out [6:0]  active-high segment pattern, bit 0 = segment a
module bto7s_suit
  import card_pkg::*;
(
  input  logic [1:0] suit_in,
  output logic [6:0] glyph_out
);

  // Decode the suit code into its glyph.
  always_comb begin
    glyph_out = GLYPH_BLANK;
    case (suit_e'(suit_in))
      SUIT_DIAMOND: glyph_out = SUIT_GLYPH[0];
      SUIT_HEART:   glyph_out = SUIT_GLYPH[1];
      SUIT_CLUB:    glyph_out = SUIT_GLYPH[2];
      SUIT_SPADE:   glyph_out = SUIT_GLYPH[3];
      default:      glyph_out = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/scan_prescaler.sv
// scan_prescaler: digit-slot cycle counter and BLANK/DRIVE phase generator.
//   clk_in, rst_n_in   clock, asynchronous active-low reset
//   slot_end_out       high on the last cycle of a slot (registered)
//   slot_end_next_out  high when the following cycle is the last of a slot
//   drive_en_out       high during the DRIVE phase (registered)
module scan_prescaler
  import card_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  output logic slot_end_out,
  output logic slot_end_next_out,
  output logic drive_en_out
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W:0]   BLANK_END = (CNT_W+1)'(BLANK_CYCLES);
  // With no blanking the slot starts directly in DRIVE.
  localparam scan_phase_e SLOT_START = (BLANK_CYCLES == 0) ? PH_DRIVE : PH_BLANK;
  localparam logic SLOT_END_RST = (DIGIT_CYCLES == 1) ? 1'b1 : 1'b0;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc_s;
  scan_phase_e      phase_q, phase_d;
  logic             slot_end_q, slot_end_d;

  assign cnt_inc_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  // Next slot count and phase.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_inc_s[CNT_W-1:0];
    end
    case (phase_q)
      PH_BLANK: begin
        if (cnt_inc_s == BLANK_END) begin
          phase_d = PH_DRIVE;
        end else begin
          phase_d = PH_BLANK;
        end
      end
      PH_DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          phase_d = SLOT_START;
        end else begin
          phase_d = PH_DRIVE;
        end
      end
      default: phase_d = SLOT_START;
    endcase
    slot_end_d = (cnt_d == CNT_LAST);
  end

  // Slot counter, phase and slot-end registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q      <= {CNT_W{1'b0}};
      phase_q    <= SLOT_START;
      slot_end_q <= SLOT_END_RST;
    end else begin
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      slot_end_q <= slot_end_d;
    end
  end

  assign slot_end_out      = slot_end_q;
  assign slot_end_next_out = slot_end_d;
  assign drive_en_out      = (phase_q == PH_DRIVE);

endmodule

// File: rtl/card_display_scan.sv
// card_display_scan: time-multiplexed 7-segment driver for a hand of cards.
// Each card occupies two digits (rank then suit). A new hand is accepted over
// valid/ready into a pending buffer and swapped into the display buffer only
// on the last cycle of a frame, so a frame never mixes two hands. Every digit
// slot starts with a blanking guard to suppress ghosting.
//   clk_in, rst_n_in   clock, asynchronous active-low reset
//   cards_in           6 bits per card: rank[5:2], suit[1:0]
//   cards_valid_in     hand offered
//   cards_ready_out    pending buffer empty
//   highlight_en_in    blink the highlighted card
//   highlight_in       index of the highlighted card
//   an_out             active-low anodes, an_out[k] = digit k
//   cat_out            active-low cathodes, bit 0 = segment a
//   frame_out          pulse on the last cycle of each frame
// Optional feature macro: CARD_DISPLAY_BLINK_EN enables the blink phase and
// frame counter; without it the highlight ports are ignored.
module card_display_scan
  import card_pkg::*;
#(
  parameter int NUM_CARDS    = 4,
  parameter int DIGIT_CYCLES = 100_000,
  parameter int BLANK_CYCLES = 1_000,
  parameter int BLINK_FRAMES = 64,
  localparam int HL_W = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [6*NUM_CARDS-1:0] cards_in,
  input  logic                   cards_valid_in,
  output logic                   cards_ready_out,
  input  logic                   highlight_en_in,
  input  logic [HL_W-1:0]        highlight_in,
  output logic [2*NUM_CARDS-1:0] an_out,
  output logic [6:0]             cat_out,
  output logic                   frame_out
);

  localparam int DIGITS = 2 * NUM_CARDS;
  localparam int DIG_W  = $clog2(DIGITS);
  localparam logic [DIG_W-1:0]  DIG_LAST     = DIG_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ONE_HOT_BASE = {{(DIGITS-1){1'b0}}, 1'b1};

  card_t [NUM_CARDS-1:0] pend_q, pend_d;
  card_t [NUM_CARDS-1:0] disp_q, disp_d;
  logic                  pend_vld_q, pend_vld_d;
  logic                  ready_q, ready_d;
  logic [DIG_W-1:0]      k_q, k_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            cat_q, cat_d;
  logic                  frame_q, frame_d;

  logic                  slot_end_s;
  logic                  slot_end_next_s;
  logic                  drive_en_s;
  logic                  accept_s;
  logic [HL_W-1:0]       card_idx_s;
  card_t                 cur_card_s;
  logic [6:0]            suit_glyph_s;
  logic [6:0]            glyph_s;
  logic                  hide_s;

  scan_prescaler #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .slot_end_out      (slot_end_s),
    .slot_end_next_out (slot_end_next_s),
    .drive_en_out      (drive_en_s)
  );

  assign accept_s   = cards_valid_in && !pend_vld_q;
  assign card_idx_s = HL_W'(k_q >> 1);
  assign cur_card_s = disp_q[card_idx_s];

  bto7s_suit u_suit (
    .suit_in   (cur_card_s.suit),
    .glyph_out (suit_glyph_s)
  );

`ifdef CARD_DISPLAY_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic            blink_q, blink_d;
  logic            hl_valid_s;

  // Frame counter: flip the blink phase after every BLINK_FRAMES frames.
  always_comb begin
    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (frame_q) begin
      if (fcnt_q == FC_LAST) begin
        fcnt_d  = {FC_W{1'b0}};
        blink_d = ~blink_q;
      end else begin
        fcnt_d  = fcnt_q + {{(FC_W-1){1'b0}}, 1'b1};
        blink_d = blink_q;
      end
    end else begin
      fcnt_d  = fcnt_q;
      blink_d = blink_q;
    end
  end

  // Frame counter and blink phase registers; phase 0 (visible) after reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fcnt_q  <= {FC_W{1'b0}};
      blink_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      blink_q <= blink_d;
    end
  end

  // An out-of-range highlight index matches no card.
  assign hl_valid_s = ({1'b0, highlight_in} < (HL_W+1)'(NUM_CARDS));
  assign hide_s     = blink_q && highlight_en_in && hl_valid_s &&
                      (highlight_in == card_idx_s);
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_highlight_s;
  assign unused_highlight_s = &{1'b0, highlight_en_in, highlight_in};
  assign hide_s = 1'b0;
`endif

  // Select the glyph for digit k: even digits carry the rank, odd the suit.
  always_comb begin
    glyph_s = GLYPH_BLANK;
    if ((cur_card_s.rank == RANK_EMPTY) || hide_s) begin
      glyph_s = GLYPH_BLANK;
    end else if (k_q[0]) begin
      glyph_s = suit_glyph_s;
    end else begin
      glyph_s = rank_glyph(cur_card_s.rank);
    end
  end

  // Digit index, frame pulse and anode/cathode next values.
  always_comb begin
    k_d   = k_q;
    an_d  = {DIGITS{1'b1}};
    cat_d = 7'h7F;
    if (slot_end_s) begin
      if (k_q == DIG_LAST) begin
        k_d = {DIG_W{1'b0}};
      end else begin
        k_d = k_q + {{(DIG_W-1){1'b0}}, 1'b1};
      end
    end else begin
      k_d = k_q;
    end
    // Registered so that the pulse lines up with the frame's last cycle.
    frame_d = slot_end_next_s && (k_d == DIG_LAST);
    if (drive_en_s) begin
      an_d  = ~(ONE_HOT_BASE << k_q);
      cat_d = ~glyph_s;
    end else begin
      an_d  = {DIGITS{1'b1}};
      cat_d = 7'h7F;
    end
  end

  // Double buffer: a pending hand moves to the display only on frame_out;
  // a hand accepted on that same cycle waits for the next frame boundary.
  always_comb begin
    pend_d     = pend_q;
    disp_d     = disp_q;
    pend_vld_d = pend_vld_q;
    if (frame_q && pend_vld_q) begin
      disp_d     = pend_q;
      pend_vld_d = 1'b0;
    end else begin
      disp_d     = disp_q;
    end
    if (accept_s) begin
      pend_d     = cards_in;
      pend_vld_d = 1'b1;
    end else begin
      pend_d     = pend_q;
    end
    ready_d = !pend_vld_d;
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pend_q     <= {NUM_CARDS{6'b000000}};
      disp_q     <= {NUM_CARDS{6'b000000}};
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      k_q        <= {DIG_W{1'b0}};
      an_q       <= {DIGITS{1'b1}};
      cat_q      <= 7'h7F;
      frame_q    <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      disp_q     <= disp_d;
      pend_vld_q <= pend_vld_d;
      ready_q    <= ready_d;
      k_q        <= k_d;
      an_q       <= an_d;
      cat_q      <= cat_d;
      frame_q    <= frame_d;
    end
  end

  assign cards_ready_out = ready_q;
  assign an_out          = an_q;
  assign cat_out         = cat_q;
  assign frame_out       = frame_q;

endmodule

// File: tb/tb_card_display_scan.sv
// Bench for card_display_scan with NUM_CARDS=4, DIGIT_CYCLES=8,
// BLANK_CYCLES=2, BLINK_FRAMES=2. Expected outputs are derived from the
// cycle number since reset and the hand history.
module tb_card_display_scan;

  localparam int N     = 4;
  localparam int D     = 8;
  localparam int B     = 2;
  localparam int BF    = 2;
  localparam int FRAME = 2 * N * D;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [23:0] cards_in = 24'h0;
  logic        cards_valid_in = 1'b0;
  logic        cards_ready_out;
  logic        highlight_en_in = 1'b0;
  logic [1:0]  highlight_in = 2'd0;
  logic [7:0]  an_out;
  logic [6:0]  cat_out;
  logic        frame_out;

  int          checks = 0;
  int          errors = 0;
  int          n = 0;
  logic [23:0] m_disp = 24'h0;
  logic [23:0] m_pend = 24'h0;
  logic        m_pend_vld = 1'b0;

  card_display_scan #(
    .NUM_CARDS    (N),
    .DIGIT_CYCLES (D),
    .BLANK_CYCLES (B),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .cards_in        (cards_in),
    .cards_valid_in  (cards_valid_in),
    .cards_ready_out (cards_ready_out),
    .highlight_en_in (highlight_en_in),
    .highlight_in    (highlight_in),
    .an_out          (an_out),
    .cat_out         (cat_out),
    .frame_out       (frame_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [6:0] rank_glyph(input int r);
    case (r)
      0:  return 7'h00;
      1:  return 7'h77;
      2:  return 7'h5B;
      3:  return 7'h4F;
      4:  return 7'h66;
      5:  return 7'h6D;
      6:  return 7'h7D;
      7:  return 7'h07;
      8:  return 7'h7F;
      9:  return 7'h6F;
      10: return 7'h78;
      11: return 7'h1E;
      12: return 7'h67;
      13: return 7'h75;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [6:0] suit_glyph(input int s);
    case (s)
      0: return 7'h5E;
      1: return 7'h74;
      2: return 7'h39;
      default: return 7'h6D;
    endcase
  endfunction

  function automatic logic [5:0] card(input int rank, input int suit);
    logic [5:0] c;
    c[5:2] = rank[3:0];
    c[1:0] = suit[1:0];
    return c;
  endfunction

  // Outputs visible one cycle after counter position cyc: {an, cat}.
  function automatic logic [14:0] expect_out(input int cyc, input logic [23:0] hand,
                                             input logic hl_en, input logic [1:0] hl);
    int slot, digit, cidx, rank, suit;
    logic hide;
    logic [6:0] glyph;
    logic [7:0] an;
    slot  = cyc % D;
    digit = (cyc / D) % (2 * N);
    cidx  = digit / 2;
    if (slot < B) return {8'hFF, 7'h7F};
    rank = int'(hand[6*cidx+2 +: 4]);
    suit = int'(hand[6*cidx +: 2]);
    hide = 1'b0;
`ifdef CARD_DISPLAY_BLINK_EN
    hide = (((cyc / FRAME) / BF) % 2 == 1) && hl_en && (int'(hl) == cidx) && (int'(hl) < N);
`endif
    if (rank == 0 || hide) glyph = 7'h00;
    else if (digit % 2 == 1) glyph = suit_glyph(suit);
    else glyph = rank_glyph(rank);
    an = 8'hFF;
    an[digit] = 1'b0;
    return {an, ~glyph};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  // Advance one clock and check all outputs against the model.
  task automatic step();
    logic [14:0] e;
    logic        acc;
    logic [23:0] acc_cards;
    logic        e_frame;
    e         = expect_out(n, m_disp, highlight_en_in, highlight_in);
    acc       = cards_valid_in && !m_pend_vld;
    acc_cards = cards_in;
    e_frame   = ((n + 1) % FRAME) == FRAME - 1;
    @(posedge clk_in);
    if ((n % FRAME) == FRAME - 1 && m_pend_vld) begin
      m_disp     = m_pend;
      m_pend_vld = 1'b0;
    end
    if (acc) begin
      m_pend     = acc_cards;
      m_pend_vld = 1'b1;
    end
    n++;
    #1;
    chk("an_out", 32'(an_out), 32'(e[14:7]));
    chk("cat_out", 32'(cat_out), 32'(e[6:0]));
    chk("frame_out", 32'(frame_out), 32'(e_frame));
    chk("cards_ready_out", 32'(cards_ready_out), 32'(!m_pend_vld));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Offer a hand and hold valid until it is accepted (bounded wait).
  task automatic post(input logic [23:0] hand);
    int waited;
    cards_in       = hand;
    cards_valid_in = 1'b1;
    waited         = 0;
    while (m_pend_vld && waited < 4 * FRAME) begin
      step();
      waited++;
    end
    chk("accept_bound", 32'(waited < 4 * FRAME), 32'd1);
    step();
    cards_valid_in = 1'b0;
  endtask

  // Assert reset away from the clock edge, check, then release on a negedge.
  task automatic do_reset(input int cycles);
    rst_n_in = 1'b0;
    #1;
    chk("rst_an", 32'(an_out), 32'hFF);
    chk("rst_cat", 32'(cat_out), 32'h7F);
    chk("rst_frame", 32'(frame_out), 32'd0);
    chk("rst_ready", 32'(cards_ready_out), 32'd1);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_in);
      #1;
      chk("rst_hold_an", 32'(an_out), 32'hFF);
      chk("rst_hold_cat", 32'(cat_out), 32'h7F);
    end
    @(negedge clk_in);
    rst_n_in   = 1'b1;
    n          = 0;
    m_disp     = 24'h0;
    m_pend     = 24'h0;
    m_pend_vld = 1'b0;
  endtask

  initial begin
    rst_n_in = 1'b1;
    #3;
    do_reset(3);
    // Empty hand: anodes strobe, cathodes stay off.
    run(FRAME);
    // Two of diamonds in card 0.
    post({card(0, 0), card(0, 0), card(0, 0), card(2, 0)});
    run(2 * FRAME);
    // Back-to-back hands: second waits for the frame swap.
    post({card(0, 0), card(0, 0), card(13, 1), card(1, 3)});
    post({card(12, 2), card(11, 1), card(10, 0), card(9, 3)});
    run(2 * FRAME);
    // Accept exactly on the frame_out cycle.
    for (int i = 0; i < FRAME && (n % FRAME) != FRAME - 1; i++) step();
    post({card(4, 1), card(5, 2), card(6, 3), card(7, 0)});
    run(3 * FRAME);
    // Illegal rank 15 with spade.
    post({card(3, 2), card(0, 1), card(14, 0), card(15, 3)});
    run(2 * FRAME);
    // Highlight card 1 from a fresh reset so frame numbers start at 0.
    do_reset(2);
    highlight_en_in = 1'b1;
    highlight_in    = 2'd1;
    post({card(8, 0), card(13, 3), card(12, 1), card(1, 2)});
    run(6 * FRAME);
    // Reset in the middle of a frame.
    for (int i = 0; i < FRAME && (n % FRAME) != 20; i++) step();
    do_reset(2);
    run(FRAME);
    // Random hands, highlights and gaps.
    for (int r = 0; r < 12; r++) begin
      logic [23:0] h;
      h = 24'($urandom);
      highlight_en_in = 1'($urandom_range(0, 1));
      highlight_in    = 2'($urandom_range(0, 3));
      post(h);
      run(int'($urandom_range(0, 100)));
    end
    run(2 * FRAME);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
